// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared constants and helpers for the LFSR stochastic-number-generator bank.
//   TAPS_16 / SEED_16 : polynomial and seeds of the legacy 16-bit generator
//   WIDTH_MIN/MAX     : legal LFSR width range
//   NCH_MIN/MAX       : legal channel-count range
//   lfsr_next()       : Galois next-state for any width up to 32 bits
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned NCH_MIN   = 1;
  localparam int unsigned NCH_MAX   = 16;

  localparam logic [15:0] TAPS_16     = 16'h0070;
  localparam logic [15:0] SEED_16_CH0 = 16'hAAAA;
  localparam logic [15:0] SEED_16_CH1 = 16'h9999;
  localparam logic [31:0] SEED_16     = {SEED_16_CH1, SEED_16_CH0};

  // Galois step: shift left, and when the MSB falls out XOR in the tap mask.
  // Bit 0 always takes feedback, so the mask is forced odd.
  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s,
    input logic [31:0] mask,
    input int unsigned width
  );
    logic [31:0] w_keep;
    logic [31:0] w_shift;
    w_keep  = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    w_shift = (s << 1) & w_keep;
    if (s[width-1]) begin
      w_shift = w_shift ^ ((mask | 32'h1) & w_keep);
    end
    return w_shift;
  endfunction

endpackage

// File: rtl/lfsr_chan.sv
// ---------------------------------------------------------------------------
// lfsr_chan
// One channel of the LFSR bank: state register, current seed, wrap/lockup
// pulses and (with LFSR_SNG_CMP_EN defined) the stochastic-bit comparator.
// Without LFSR_SNG_CMP_EN, o_sn is tied low and i_thresh is unused.
//   clk, rst    : clock, asynchronous active-high reset
//   i_en        : advance enable
//   i_load      : reseed this channel (already decoded by the top)
//   i_seed      : new seed
//   i_thresh    : comparator threshold
//   o_state     : current LFSR state
//   o_wrap      : pulse, state just returned to the current seed via an en step
//   o_lockup    : pulse, zero state or zero seed was corrected
//   o_sn        : stochastic bit, (state < thresh) one clock late
// ---------------------------------------------------------------------------
module lfsr_chan
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = TAPS_16[WIDTH-1:0],
  parameter logic [WIDTH-1:0]  SEED  = SEED_16_CH0[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_thresh,
  output logic [WIDTH-1:0] o_state,
  output logic             o_wrap,
  output logic             o_lockup,
  output logic             o_sn
);

  // An all-zero seed would freeze the LFSR; substitute 1.
  localparam logic [WIDTH-1:0] RST_SEED = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_cur_seed;
  logic             r_wrap;
  logic             r_lockup;
  logic [WIDTH-1:0] w_nxt;

  assign w_nxt = WIDTH'(lfsr_next(32'(r_state), 32'(TAPS), WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_SEED;
      r_cur_seed <= RST_SEED;
      r_wrap     <= 1'b0;
      r_lockup   <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
      if (i_load) begin
        // Load overrides en for this cycle only.
        if (i_seed == '0) begin
          r_state    <= WIDTH'(1);
          r_cur_seed <= WIDTH'(1);
          r_lockup   <= 1'b1;
        end else begin
          r_state    <= i_seed;
          r_cur_seed <= i_seed;
        end
      end else if (r_state == '0) begin
        // Only reachable with a degenerate tap mask.
        r_state  <= r_cur_seed;
        r_lockup <= 1'b1;
      end else if (i_en) begin
        r_state <= w_nxt;
        r_wrap  <= (w_nxt == r_cur_seed);
      end
    end
  end

  assign o_state  = r_state;
  assign o_wrap   = r_wrap;
  assign o_lockup = r_lockup;

`ifdef LFSR_SNG_CMP_EN
  logic r_sn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sn <= 1'b0;
    end else begin
      r_sn <= (r_state < i_thresh);
    end
  end

  assign o_sn = r_sn;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^i_thresh;
  assign o_sn            = 1'b0;
`endif

endmodule

// File: rtl/lfsr_sng_bank.sv
// ---------------------------------------------------------------------------
// lfsr_sng_bank
// Bank of NCH independent Galois LFSRs used as random-number sources for the
// stochastic-computing datapath. Defaults reproduce the legacy 16-bit
// two-channel generator. Define LFSR_SNG_CMP_EN to build the per-channel
// comparators that drive sn_out; otherwise sn_out is 0 and thresh is unused.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : per-channel advance enable
//   load      : reseed strobe for channel load_ch (ignored if load_ch >= NCH)
//   load_ch   : channel to reseed
//   seed_in   : new seed
//   thresh    : packed per-channel comparator thresholds
//   countval  : packed per-channel LFSR state
//   wrap      : per-channel period-wrap pulse
//   lockup    : per-channel zero-correction pulse
//   sn_out    : per-channel stochastic bit
// ---------------------------------------------------------------------------
module lfsr_sng_bank
  import lfsr_pkg::*;
#(
  parameter int unsigned           WIDTH = 16,
  parameter int unsigned           NCH   = 2,
  parameter logic [WIDTH-1:0]      TAPS  = TAPS_16[WIDTH-1:0],
  parameter logic [NCH*WIDTH-1:0]  SEED  = (NCH*WIDTH)'(SEED_16),
  localparam int unsigned          LCW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic                 load,
  input  logic [LCW-1:0]       load_ch,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic [NCH*WIDTH-1:0] thresh,
  output logic [NCH*WIDTH-1:0] countval,
  output logic [NCH-1:0]       wrap,
  output logic [NCH-1:0]       lockup,
  output logic [NCH-1:0]       sn_out
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("lfsr_sng_bank: WIDTH out of range");
  end
  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("lfsr_sng_bank: NCH out of range");
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      // An out-of-range load_ch matches no channel, so the load is dropped.
      logic w_load_hit;
      assign w_load_hit = load && (load_ch == LCW'(gi));

      lfsr_chan #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED[gi*WIDTH +: WIDTH])
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .i_en     (en[gi]),
        .i_load   (w_load_hit),
        .i_seed   (seed_in),
        .i_thresh (thresh[gi*WIDTH +: WIDTH]),
        .o_state  (countval[gi*WIDTH +: WIDTH]),
        .o_wrap   (wrap[gi]),
        .o_lockup (lockup[gi]),
        .o_sn     (sn_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_lfsr_sng_bank.sv
// ---------------------------------------------------------------------------
// tb_lfsr_sng_bank
// Directed bench: default 16-bit two-channel bank (dut_a) and a 4-bit
// single-channel bank with mask 4'h2 (dut_b) sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_lfsr_sng_bank;

`ifdef LFSR_SNG_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a: defaults
  logic [1:0]  en_a      = '0;
  logic        load_a    = 1'b0;
  logic [0:0]  load_ch_a = '0;
  logic [15:0] seed_a    = '0;
  logic [31:0] thresh_a  = {16'hFFFF, 16'h0000};
  logic [31:0] countval_a;
  logic [1:0]  wrap_a, lockup_a, sn_a;

  // dut_b: WIDTH=4, NCH=1, TAPS=4'h2, seed 1
  logic [0:0]  en_b      = '0;
  logic        load_b    = 1'b0;
  logic [0:0]  load_ch_b = '0;
  logic [3:0]  seed_b    = '0;
  logic [3:0]  thresh_b  = 4'h8;
  logic [3:0]  countval_b;
  logic [0:0]  wrap_b, lockup_b, sn_b;

  lfsr_sng_bank dut_a (
    .clk(clk), .rst(rst), .en(en_a), .load(load_a), .load_ch(load_ch_a),
    .seed_in(seed_a), .thresh(thresh_a), .countval(countval_a),
    .wrap(wrap_a), .lockup(lockup_a), .sn_out(sn_a)
  );

  lfsr_sng_bank #(.WIDTH(4), .NCH(1), .TAPS(4'h2), .SEED(4'h1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .load(load_b), .load_ch(load_ch_b),
    .seed_in(seed_b), .thresh(thresh_b), .countval(countval_b),
    .wrap(wrap_b), .lockup(lockup_b), .sn_out(sn_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed period of the 4-bit LFSR with mask 4'h2 from seed 1.
  logic [3:0] b_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                             4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

  initial begin
    int wrap_cnt;
    int ones;
    logic [15:0] seen;

    // Reset state
    #12;
    check("rst_countval_a", countval_a, 32'h9999_AAAA);
    check("rst_wrap_a", 32'(wrap_a), 32'h0);
    check("rst_lockup_a", 32'(lockup_a), 32'h0);
    check("rst_sn_a", 32'(sn_a), 32'h0);
    check("rst_countval_b", 32'(countval_b), 32'h1);

    // Release reset, one advance on both channels
    rst = 1'b0;
    step();
    en_a = 2'b11;
    step();
    en_a = 2'b00;
    check("step1_countval_a", countval_a, 32'h3343_5525);
    check("step1_wrap_a", 32'(wrap_a), 32'h0);
    check("step1_lockup_a", 32'(lockup_a), 32'h0);
    // sn reflects the reset states: ch0 AAAA<0 false, ch1 9999<FFFF true
    check("step1_sn_a", 32'(sn_a), CMP ? 32'h2 : 32'h0);

    // Load ch1 with en on both: ch1 takes the seed, ch0 advances
    load_a = 1'b1; load_ch_a = 1'b1; seed_a = 16'h1234; en_a = 2'b11;
    step();
    load_a = 1'b0; en_a = 2'b00;
    check("load_countval_a", countval_a, 32'h1234_AA4A);
    check("load_lockup_a", 32'(lockup_a), 32'h0);

    // Load zero seed: corrected to 1 with lockup pulse on ch1
    load_a = 1'b1; load_ch_a = 1'b1; seed_a = 16'h0000;
    step();
    load_a = 1'b0;
    check("load0_countval_a", countval_a, 32'h0001_AA4A);
    check("load0_lockup_a", 32'(lockup_a), 32'h2);
    step();
    check("load0_lockup_clear_a", 32'(lockup_a), 32'h0);

    // Stream, then assert reset asynchronously between edges
    en_a = 2'b11;
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_countval_a", countval_a, 32'h9999_AAAA);
    check("arst_wrap_a", 32'(wrap_a), 32'h0);
    check("arst_lockup_a", 32'(lockup_a), 32'h0);
    check("arst_sn_a", 32'(sn_a), 32'h0);
    check("arst_countval_b", 32'(countval_b), 32'h1);
    en_a = 2'b00;
    step();
    rst = 1'b0;

    // dut_b: full period, wrap cadence and comparator density
    en_b = 1'b1;
    wrap_cnt = 0;
    ones = 0;
    seen = '0;
    for (int n = 1; n <= 30; n++) begin
      step();
      check($sformatf("b_state_%0d", n), 32'(countval_b), 32'(b_seq[n % 15]));
      check($sformatf("b_wrap_%0d", n), 32'(wrap_b), (n % 15 == 0) ? 32'h1 : 32'h0);
      if (wrap_b[0]) wrap_cnt++;
      seen[countval_b] = 1'b1;
      if (n >= 2 && n <= 16 && sn_b[0]) ones++;
    end
    en_b = 1'b0;
    check("b_wrap_count", 32'(wrap_cnt), 32'd2);
    check("b_states_seen", 32'(seen), 32'h0000_FFFE);
    check("b_sn_ones", 32'(ones), CMP ? 32'd7 : 32'd0);

    // Out-of-range load_ch on the single-channel bank: nothing changes
    load_b = 1'b1; load_ch_b = 1'b1; seed_b = 4'h5;
    step();
    load_b = 1'b0;
    check("oor_countval_b", 32'(countval_b), 32'(b_seq[0]));
    check("oor_lockup_b", 32'(lockup_b), 32'h0);
    check("oor_wrap_b", 32'(wrap_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
